// File: rtl/avalon_hex_pio.sv
// avalon_hex_pio: Avalon-MM PIO driving hex-decoded active-low 7-seg digits with enable/blink,
// plus a synchronised input port with rising-edge capture and a maskable level interrupt.
module avalon_hex_pio #(
    parameter int NUM_DIGITS = 6,
    parameter int IN_WIDTH   = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    irq,
    input  logic [IN_WIDTH-1:0]     pio_in,
    output logic [NUM_DIGITS*7-1:0] HEX
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BLINK_DIV);

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    logic [DW-1:0]           data_reg;
    logic [NUM_DIGITS-1:0]   enable_reg;
    logic [NUM_DIGITS-1:0]   blink_reg;
    logic [IN_WIDTH-1:0]     in_s1;
    logic [IN_WIDTH-1:0]     in_s2;
    logic [IN_WIDTH-1:0]     in_p;
    logic [IN_WIDTH-1:0]     edge_cap;
    logic [IN_WIDTH-1:0]     irq_mask;
    logic [IN_WIDTH-1:0]     edge_clr;
    logic [CW-1:0]           cnt;
    logic                    phase;
    logic                    wrap;
    logic [31:0]             rd_mux;
    logic [NUM_DIGITS*7-1:0] hex_next;
    logic                    unused_wd;

    assign unused_wd = &{1'b0, avs_writedata};
    assign wrap      = cnt == CW'(BLINK_DIV - 1);
    assign edge_clr  = (avs_write && avs_address == 3'd4) ? avs_writedata[IN_WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = avs_address == 3'd0 ? 32'(data_reg) :
                 avs_address == 3'd1 ? 32'(enable_reg) :
                 avs_address == 3'd2 ? 32'(blink_reg) :
                 avs_address == 3'd3 ? 32'(in_s2) :
                 avs_address == 3'd4 ? 32'(edge_cap) :
                 avs_address == 3'd5 ? 32'(irq_mask) : 32'd0;
    end

    always_comb begin
        hex_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            hex_next[7*i +: 7] = (!enable_reg[i] || (blink_reg[i] && phase)) ? 7'h7F : seg(data_reg[4*i +: 4]);
    end

    // Edge capture: a new rising edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_reg     <= '0;
            enable_reg   <= '1;
            blink_reg    <= '0;
            in_s1        <= '0;
            in_s2        <= '0;
            in_p         <= '0;
            edge_cap     <= '0;
            irq_mask     <= '0;
            cnt          <= '0;
            phase        <= 1'b0;
            irq          <= 1'b0;
            avs_readdata <= '0;
            HEX          <= {NUM_DIGITS{7'h40}};
        end else begin
            if (avs_write && avs_address == 3'd0) data_reg <= avs_writedata[DW-1:0];
            if (avs_write && avs_address == 3'd1) enable_reg <= avs_writedata[NUM_DIGITS-1:0];
            if (avs_write && avs_address == 3'd2) blink_reg <= avs_writedata[NUM_DIGITS-1:0];
            if (avs_write && avs_address == 3'd5) irq_mask <= avs_writedata[IN_WIDTH-1:0];
            in_s1        <= pio_in;
            in_s2        <= in_s1;
            in_p         <= in_s2;
            edge_cap     <= (edge_cap & ~edge_clr) | (in_s2 & ~in_p);
            cnt          <= wrap ? '0 : cnt + CW'(1);
            phase        <= phase ^ wrap;
            irq          <= |(edge_cap & irq_mask);
            avs_readdata <= avs_read ? rd_mux : avs_readdata;
            HEX          <= hex_next;
        end
    end
endmodule

// File: tb/tb_avalon_hex_pio.sv
// tb_avalon_hex_pio: directed vectors with hand-computed expectations for avalon_hex_pio
// (6 digits, 4 inputs, blink half-period of 4 cycles).
module tb_avalon_hex_pio;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [3:0]  pio_in = '0;
    logic [41:0] HEX;
    int          n_chk = 0;
    int          n_fail = 0;

    avalon_hex_pio #(.NUM_DIGITS(6), .IN_WIDTH(4), .BLINK_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .pio_in(pio_in), .HEX(HEX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        tick(1);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        tick(1);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    logic [31:0] r;
    logic [6:0]  v;
    logic [6:0]  prev;
    logic        found;

    initial begin
        // reset state
        tick(2);
        chk("rst_hex", 64'(HEX), 64'({6{7'h40}}));
        chk("rst_rdata", 64'(avs_readdata), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        RST = 1'b0;
        rd(3'd1, r);
        chk("rst_enable", 64'(r), 64'h3F);
        tick(2);
        chk("rdata_hold", 64'(avs_readdata), 64'h3F);

        // decode and readback
        wr(3'd0, 32'h00FA5123);
        chk("hex_lat", 64'(HEX), 64'({6{7'h40}}));
        tick(1);
        chk("hex_decode", 64'(HEX), 64'({7'h0E, 7'h08, 7'h12, 7'h79, 7'h24, 7'h30}));
        rd(3'd0, r);
        chk("rd_data", 64'(r), 64'h00FA5123);
        avs_writedata = 32'h00654321;
        avs_write = 1'b1;
        rd(3'd0, r);
        avs_write = 1'b0;
        chk("rw_old", 64'(r), 64'h00FA5123);
        rd(3'd0, r);
        chk("rw_new", 64'(r), 64'h00654321);
        wr(3'd7, 32'hFFFFFFFF);
        rd(3'd7, r);
        chk("rd_addr7", 64'(r), 64'h0);

        // enable and blink
        wr(3'd1, 32'hFFFFFFFE);
        wr(3'd2, 32'h00000002);
        rd(3'd1, r);
        chk("rd_enable", 64'(r), 64'h3E);
        rd(3'd2, r);
        chk("rd_blink", 64'(r), 64'h02);
        found = 1'b0;
        prev = HEX[13:7];
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (HEX[13:7] != prev) found = 1'b1;
        end
        chk("blink_toggle", 64'(found), 64'h1);
        v = HEX[13:7];
        chk("blink_val", 64'(v == 7'h24 || v == 7'h7F), 64'h1);
        for (int k = 1; k < 4; k++) begin
            tick(1);
            chk("blink_hold", 64'(HEX[13:7]), 64'(v));
            chk("steady", 64'({HEX[41:14], HEX[6:0]}), 64'({7'h02, 7'h12, 7'h19, 7'h30, 7'h7F}));
        end
        tick(1);
        chk("blink_flip", 64'(HEX[13:7]), 64'(v == 7'h7F ? 7'h24 : 7'h7F));

        // edge capture and irq timing
        wr(3'd5, 32'h1);
        pio_in[0] = 1'b1;
        tick(3);
        chk("irq_lat_edge3", 64'(irq), 64'h0);
        tick(1);
        chk("irq_set", 64'(irq), 64'h1);
        rd(3'd4, r);
        chk("edge_set", 64'(r), 64'h1);
        rd(3'd3, r);
        chk("in_read", 64'(r), 64'h1);
        wr(3'd4, 32'h1);
        chk("irq_hold_clr", 64'(irq), 64'h1);
        tick(1);
        chk("irq_clr", 64'(irq), 64'h0);
        pio_in[0] = 1'b0;
        tick(4);
        rd(3'd4, r);
        chk("fall_ignored", 64'(r), 64'h0);
        chk("fall_irq", 64'(irq), 64'h0);

        // set beats simultaneous clear
        pio_in[1] = 1'b1;
        tick(2);
        wr(3'd4, 32'h2);
        rd(3'd4, r);
        chk("set_wins", 64'(r), 64'h2);
        chk("unmasked_irq", 64'(irq), 64'h0);
        wr(3'd4, 32'h2);
        rd(3'd4, r);
        chk("clr_bit1", 64'(r), 64'h0);

        // asynchronous reset mid-operation
        pio_in[0] = 1'b1;
        tick(4);
        chk("pre_rst_irq", 64'(irq), 64'h1);
        rd(3'd0, r);
        chk("pre_rst_rdata", 64'(r), 64'h00654321);
        avs_address = 3'd0;
        avs_read = 1'b1;
        #3 RST = 1'b1;
        #1;
        chk("arst_hex", 64'(HEX), 64'({6{7'h40}}));
        chk("arst_irq", 64'(irq), 64'h0);
        chk("arst_rdata", 64'(avs_readdata), 64'h0);
        avs_read = 1'b0;
        tick(2);
        chk("arst_rdata_hold", 64'(avs_readdata), 64'h0);
        RST = 1'b0;
        tick(3);
        rd(3'd4, r);
        chk("edge_after_rst", 64'(r), 64'h3);
        chk("irq_mask_rst", 64'(irq), 64'h0);
        rd(3'd1, r);
        chk("enable_after_rst", 64'(r), 64'h3F);
        rd(3'd0, r);
        chk("data_after_rst", 64'(r), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
